// File: rtl/aer_out_sink.sv
// AER output sink: completes 4-phase handshakes from the core and keeps
// per-neuron spike counts, a total event count and an address-error flag.
// Ports:
//   CLK, RST_N (sync, active-low)
//   AEROUT_ADDR/AEROUT_REQ in, AEROUT_ACK out (4-phase handshake)
//   SAMPLE_CLR in (clears counters and ADDR_ERR)
//   RD_ADDR in -> RD_CNT out (1-cycle read latency)
//   TOTAL_CNT, ADDR_ERR, BUSY out
module aer_out_sink #(
   parameter int AER_WIDTH   = 12,
   parameter int NUM_NEURON  = 256,
   parameter int ACK_DELAY   = 6,
   parameter int CNT_WIDTH   = 7,
   parameter int TOTAL_WIDTH = 16,
   localparam int NW         = $clog2(NUM_NEURON)
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [AER_WIDTH-1:0]   AEROUT_ADDR,
   input  logic                   AEROUT_REQ,
   output logic                   AEROUT_ACK,
   input  logic                   SAMPLE_CLR,
   input  logic [NW-1:0]          RD_ADDR,
   output logic [CNT_WIDTH-1:0]   RD_CNT,
   output logic [TOTAL_WIDTH-1:0] TOTAL_CNT,
   output logic                   ADDR_ERR,
   output logic                   BUSY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam logic [5:0] DLY = 6'(ACK_DELAY);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
   localparam logic [TOTAL_WIDTH-1:0] TOT_ONE = 1;

   state_t         state, state_n;
   logic [5:0]     dly, dly_n;
   logic           ack_n;
   logic           accept;

   logic [CNT_WIDTH-1:0] cnt [NUM_NEURON];
   logic [NW-1:0]        idx;
   logic                 addr_ok;
   logic                 rd_ok;

   assign idx     = AEROUT_ADDR[NW-1:0];
   assign addr_ok = 32'(AEROUT_ADDR) < NUM_NEURON;
   assign rd_ok   = 32'(RD_ADDR) < NUM_NEURON;

   // state register
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         dly        <= '0;
         AEROUT_ACK <= 1'b0;
      end else begin
         state      <= state_n;
         dly        <= dly_n;
         AEROUT_ACK <= ack_n;
      end
   end

   // next-state logic; an event is accepted only when leaving IDLE
   always_comb begin
      state_n = state;
      dly_n   = dly;
      ack_n   = AEROUT_ACK;
      accept  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (AEROUT_REQ) begin
               state_n = S_WAIT;
               dly_n   = DLY;
               accept  = 1'b1;
            end
         end
         S_WAIT: begin
            if (dly == '0) begin
               state_n = S_ACK;
               ack_n   = 1'b1;
            end else begin
               dly_n = dly - 6'd1;
            end
         end
         S_ACK: begin
            if (!AEROUT_REQ) begin
               state_n = S_IDLE;
               ack_n   = 1'b0;
            end
         end
         default: begin
            state_n = S_IDLE;
            ack_n   = 1'b0;
         end
      endcase
   end

   // outputs decoded from state
   always_comb begin
      BUSY = (state != S_IDLE);
   end

   // counters; a clear in the same cycle drops the accepted event
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_NEURON; i++) begin
            cnt[i] <= '0;
         end
         TOTAL_CNT <= '0;
         ADDR_ERR  <= 1'b0;
         RD_CNT    <= '0;
      end else begin
         RD_CNT <= rd_ok ? cnt[RD_ADDR] : '0;
         if (SAMPLE_CLR) begin
            for (int i = 0; i < NUM_NEURON; i++) begin
               cnt[i] <= '0;
            end
            TOTAL_CNT <= '0;
            ADDR_ERR  <= 1'b0;
         end else if (accept) begin
            if (addr_ok) begin
               if (cnt[idx] != '1) begin
                  cnt[idx] <= cnt[idx] + CNT_ONE;
               end
               if (TOTAL_CNT != '1) begin
                  TOTAL_CNT <= TOTAL_CNT + TOT_ONE;
               end
            end else begin
               ADDR_ERR <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aer_out_sink.sv
// Bench for aer_out_sink: directed vector table, hand sequences for
// clear/reset corner cases, and random events against a count model.
module tb_aer_out_sink;

   localparam int D    = 6;
   localparam int NN   = 256;
   localparam int CMAX = 127;
   localparam int TMAX = 65535;

   logic        clk;
   logic        rst_n;
   logic [11:0] addr;
   logic        req;
   logic        ack;
   logic        sample_clr;
   logic [7:0]  rd_addr;
   logic [6:0]  rd_cnt;
   logic [15:0] total_cnt;
   logic        addr_err;
   logic        busy;

   int cmp = 0;
   int bad = 0;

   int m_cnt [NN];
   int m_total;
   int m_err;

   aer_out_sink dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .AEROUT_ADDR(addr),
      .AEROUT_REQ (req),
      .AEROUT_ACK (ack),
      .SAMPLE_CLR (sample_clr),
      .RD_ADDR    (rd_addr),
      .RD_CNT     (rd_cnt),
      .TOTAL_CNT  (total_cnt),
      .ADDR_ERR   (addr_err),
      .BUSY       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int reps;
      int rd;
      int exp_cnt;
      int exp_total;
      int exp_err;
   } vec_t;

   vec_t tv [5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      cmp++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < NN; i++) m_cnt[i] = 0;
      m_total = 0;
      m_err   = 0;
   endtask

   task automatic m_event(input int a);
      if (a < NN) begin
         if (m_cnt[a] < CMAX) m_cnt[a]++;
         if (m_total < TMAX) m_total++;
      end else begin
         m_err = 1;
      end
   endtask

   task automatic read_cnt(input int a, output int v);
      rd_addr = 8'(a);
      step();
      v = int'(rd_cnt);
   endtask

   // one full handshake; optional clear pulse on the accepting edge and
   // optional cycles of REQ held high after ACK
   task automatic handshake(input int a, input bit clr, input int hold);
      int n;
      bit got;
      req        = 1'b1;
      addr       = 12'(a);
      sample_clr = clr;
      n   = 0;
      got = 0;
      while (!got && n < 100) begin
         step();
         n++;
         sample_clr = 1'b0;
         addr       = 12'($urandom);
         if (n == 1) chk("busy_wait", int'(busy), 1);
         if (ack) got = 1;
      end
      if (clr) m_clear();
      else m_event(a);
      chk("ack_latency", n, D + 2);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("ack_hold", int'(ack), 1);
      end
      req = 1'b0;
      step();
      chk("ack_fall", int'(ack), 0);
      chk("busy_idle", int'(busy), 0);
   endtask

   initial begin
      int v;
      int n;
      bit got;

      tv[0] = '{addr: 5,   reps: 1,   rd: 5,   exp_cnt: 1,
                exp_total: 1,   exp_err: 0};
      tv[1] = '{addr: 3,   reps: 10,  rd: 3,   exp_cnt: 10,
                exp_total: 11,  exp_err: 0};
      tv[2] = '{addr: 0,   reps: 130, rd: 0,   exp_cnt: 127,
                exp_total: 141, exp_err: 0};
      tv[3] = '{addr: 300, reps: 1,   rd: 0,   exp_cnt: 127,
                exp_total: 141, exp_err: 1};
      tv[4] = '{addr: 255, reps: 2,   rd: 255, exp_cnt: 2,
                exp_total: 143, exp_err: 1};

      rst_n      = 1'b0;
      req        = 1'b0;
      addr       = '0;
      sample_clr = 1'b0;
      rd_addr    = '0;
      m_clear();
      step();
      step();
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_total", int'(total_cnt), 0);
      chk("rst_err", int'(addr_err), 0);
      chk("rst_rdcnt", int'(rd_cnt), 0);
      rst_n = 1'b1;
      step();

      // directed table
      for (int t = 0; t < 5; t++) begin
         for (int r = 0; r < tv[t].reps; r++) begin
            handshake(tv[t].addr, 1'b0, (r == 0) ? 3 : 0);
         end
         read_cnt(tv[t].rd, v);
         chk("tbl_cnt", v, tv[t].exp_cnt);
         chk("tbl_total", int'(total_cnt), tv[t].exp_total);
         chk("tbl_err", int'(addr_err), tv[t].exp_err);
      end

      // clear wipes error flag and counts
      sample_clr = 1'b1;
      step();
      sample_clr = 1'b0;
      m_clear();
      chk("clr_err", int'(addr_err), 0);
      chk("clr_total", int'(total_cnt), 0);
      read_cnt(0, v);
      chk("clr_cnt0", v, 0);

      // clear coincident with accepted event on 7
      handshake(7, 1'b1, 0);
      read_cnt(7, v);
      chk("clrev_cnt7", v, 0);
      chk("clrev_total", int'(total_cnt), 0);

      // random events vs model
      for (int k = 0; k < 60; k++) begin
         handshake(int'($urandom_range(0, 319)),
                   ($urandom_range(0, 9) == 0), 0);
      end
      chk("rnd_total", int'(total_cnt), m_total);
      chk("rnd_err", int'(addr_err), m_err);
      for (int a = 0; a < NN; a++) begin
         read_cnt(a, v);
         chk("rnd_cnt", v, m_cnt[a]);
      end

      // reset in the middle of WAIT with REQ held
      req  = 1'b1;
      addr = 12'd9;
      step();
      step();
      step();
      chk("mid_busy", int'(busy), 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_ack", int'(ack), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_total", int'(total_cnt), 0);
      chk("mid_rst_err", int'(addr_err), 0);
      m_clear();
      rst_n = 1'b1;
      n   = 0;
      got = 0;
      while (!got && n < 100) begin
         step();
         n++;
         if (ack) got = 1;
      end
      m_event(9);
      chk("mid_latency", n, D + 2);
      req = 1'b0;
      step();
      chk("mid_ack_fall", int'(ack), 0);
      chk("mid_total", int'(total_cnt), m_total);
      read_cnt(9, v);
      chk("mid_cnt9", v, m_cnt[9]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
